// File: rtl/fifo_burst_rd_pkg.sv
// Shared types and width helpers for the FIFO burst reader.
package fifo_burst_rd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Number of bits needed to hold the value n (not n-1).
    function automatic int bits(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fifo_burst_rd_if.sv
// Bundle between the burst reader, its upstream FWFT FIFO and the output stream.
//
// Handshake: a beat transfers on every rising clk edge where m_valid && m_ready.
// While m_valid is high and m_ready low, m_data, m_last and m_len hold steady.
// pop is the FIFO read enable and equals the stream handshake.
interface fifo_burst_rd_if
    import fifo_burst_rd_pkg::*;
#(
    parameter type DATA_ITEM_TYPE = logic,
    parameter int  DEPTH          = 32,
    parameter int  BURST_LEN      = 8
);
    localparam int DATA_COUNT_W = bits(DEPTH);
    localparam int BEAT_W       = bits(BURST_LEN);

    // FIFO side
    DATA_ITEM_TYPE           head;
    logic                    empty;
    logic [DATA_COUNT_W-1:0] data_count;
    logic                    rd_rst_busy;
    logic                    pop;
    // Stream side
    DATA_ITEM_TYPE           m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_last;
    logic [BEAT_W-1:0]       m_len;
    // Status
    logic                    busy;

    // Burst reader view
    modport master (
        input  head, empty, data_count, rd_rst_busy, m_ready,
        output pop, m_data, m_valid, m_last, m_len, busy
    );

    // Environment view (FIFO plus stream consumer)
    modport slave (
        output head, empty, data_count, rd_rst_busy, m_ready,
        input  pop, m_data, m_valid, m_last, m_len, busy
    );

endinterface

// File: rtl/fifo_burst_rd_timer.sv
// Idle timer for partial-burst flush; instantiated only when
// FIFO_BURST_RD_TIMEOUT_EN is defined. Counts enabled cycles and saturates
// at TIMEOUT-1, where expired is raised.
module burst_timer_m #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next count: clear wins, otherwise count up until saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_burst_rd.sv
// Burst reader behind a FWFT FIFO: waits for BURST_LEN stored items, then
// drains exactly that many onto a valid/ready stream with m_last on the final
// beat. Define FIFO_BURST_RD_TIMEOUT_EN to also flush a partial burst after
// TIMEOUT idle cycles with data waiting.
module fifo_burst_rd_m
    import fifo_burst_rd_pkg::*;
#(
    parameter type DATA_ITEM_TYPE = logic,
    parameter int  DEPTH          = 32,
    parameter int  BURST_LEN      = 8,
    parameter int  TIMEOUT        = 64
) (
    input logic             clk,
    input logic             rst,
    fifo_burst_rd_if.master bus
);
    localparam int DATA_COUNT_W = bits(DEPTH);
    localparam int BEAT_W       = bits(BURST_LEN);

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] len_q, len_d;

    logic          in_burst;
    logic          valid;
    logic          hs;
    logic          last;
    logic          full_go;
    logic          part_go;
    DATA_ITEM_TYPE head_w;

    // Outputs are forced quiet while reset is asserted so nothing is popped.
    assign in_burst = rst && (state_q == BURST);
    assign valid    = in_burst && !bus.empty;
    assign hs       = valid && bus.m_ready;
    assign last     = valid && (beat_q == len_q - BEAT_W'(1));
    assign full_go  = !bus.rd_rst_busy && (bus.data_count >= DATA_COUNT_W'(BURST_LEN));

`ifdef FIFO_BURST_RD_TIMEOUT_EN
    logic tmr_en;
    logic tmr_expired;

    // Timer runs only while idle with data present and the FIFO out of reset.
    assign tmr_en = rst && (state_q == IDLE) && !bus.empty && !bus.rd_rst_busy;

    burst_timer_m #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!tmr_en),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    assign part_go = tmr_en && tmr_expired;
`else
    assign part_go = 1'b0;
`endif

    assign head_w      = bus.head;
    assign bus.m_data  = head_w;
    assign bus.m_valid = valid;
    assign bus.pop     = hs;
    assign bus.m_last  = last;
    assign bus.m_len   = in_burst ? len_q : '0;
    assign bus.busy    = in_burst;

    // Next-state: start a full (or timed-out partial) burst, count beats, end on last.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (full_go) begin
                    state_d = BURST;
                    len_d   = BEAT_W'(BURST_LEN);
                    beat_d  = '0;
                end else if (part_go) begin
                    state_d = BURST;
                    len_d   = BEAT_W'(bus.data_count);
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (hs) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, beat and length registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_rd_m.sv
// Bench for fifo_burst_rd_m: behavioural FIFO, transaction-level burst model,
// scoreboard of expected items, directed scenarios then random traffic.
module tb_fifo_burst_rd_m;
    localparam int DEPTH = 32;
    localparam int BL    = 8;
    localparam int TMO   = 16;

    logic clk;
    logic rst;

    fifo_burst_rd_if #(.DATA_ITEM_TYPE(logic [7:0]), .DEPTH(DEPTH), .BURST_LEN(BL)) bus();

    fifo_burst_rd_m #(
        .DATA_ITEM_TYPE (logic [7:0]),
        .DEPTH          (DEPTH),
        .BURST_LEN      (BL),
        .TIMEOUT        (TMO)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO contents, scoreboard and burst model
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic [7:0] push_val = 8'h00;
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         mdl_busy = 1'b0;
    int         mdl_len  = 0;
    int         mdl_beat = 0;
    int         mdl_tmr  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        bus.empty      = (fq.size() == 0);
        bus.data_count = 6'(fq.size());
        bus.head       = (fq.size() > 0) ? fq[0] : 8'h00;
    endtask

    // One clock cycle: apply inputs, check outputs at negedge, advance model and FIFO.
    task automatic run_cycle(input bit do_push, input bit rdy, input bit rrb, input bit rst_n);
        bit         exp_valid;
        bit         exp_last;
        bit         exp_hs;
        bit         dut_pop;
        bit         tmr_en;
        int         n;
        logic [7:0] want;
        bus.m_ready     = rdy;
        bus.rd_rst_busy = rrb;
        rst             = rst_n;
        @(negedge clk);
        n         = fq.size();
        exp_valid = rst_n && mdl_busy && (n > 0);
        exp_last  = exp_valid && (mdl_beat == mdl_len - 1);
        exp_hs    = exp_valid && rdy;
        check_eq("m_valid", 32'(bus.m_valid), 32'(exp_valid));
        check_eq("pop", 32'(bus.pop), 32'(exp_hs));
        check_eq("busy", 32'(bus.busy), 32'(rst_n && mdl_busy));
        check_eq("m_len", 32'(bus.m_len), (rst_n && mdl_busy) ? 32'(mdl_len) : 32'd0);
        check_eq("m_last", 32'(bus.m_last), 32'(exp_last));
        if (exp_valid) begin
            if (exp_q.size() > 0) begin
                want = exp_q[0];
                check_eq("m_data", 32'(bus.m_data), 32'(want));
                if (exp_hs) void'(exp_q.pop_front());
            end else begin
                check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end
        end
        dut_pop = bus.pop;
        // Burst rules at transaction level
        if (!rst_n) begin
            mdl_busy = 1'b0;
            mdl_len  = 0;
            mdl_beat = 0;
            mdl_tmr  = 0;
        end else begin
            tmr_en = !mdl_busy && (n > 0) && !rrb;
            if (mdl_busy) begin
                if (exp_hs) begin
                    mdl_beat++;
                    if (mdl_beat == mdl_len) mdl_busy = 1'b0;
                end
            end else if (!rrb && n >= BL) begin
                mdl_busy = 1'b1;
                mdl_len  = BL;
                mdl_beat = 0;
            end
`ifdef FIFO_BURST_RD_TIMEOUT_EN
            else if (tmr_en && mdl_tmr == TMO - 1) begin
                mdl_busy = 1'b1;
                mdl_len  = n;
                mdl_beat = 0;
            end
`endif
            mdl_tmr = tmr_en ? ((mdl_tmr + 1 > TMO - 1) ? TMO - 1 : mdl_tmr + 1) : 0;
        end
        @(posedge clk);
        #1;
        if (dut_pop && fq.size() > 0) void'(fq.pop_front());
        if (do_push) begin
            fq.push_back(push_val);
            exp_q.push_back(push_val);
            push_val++;
        end
        drive_fifo();
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) run_cycle(1'b0, rdy, 1'b0, 1'b1);
    endtask

    task automatic push_n(input int n, input bit rdy, input bit rrb);
        for (int i = 0; i < n; i++) run_cycle(1'b1, rdy, rrb, 1'b1);
    endtask

    initial begin
        rst             = 1'b0;
        bus.m_ready     = 1'b0;
        bus.rd_rst_busy = 1'b0;
        drive_fifo();
        @(posedge clk);
        #1;
        // Reset state
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Single full burst
        push_n(8, 1'b1, 1'b0);
        idle_cycles(15, 1'b1);
        check_eq("burst1_drained", 32'(fq.size()), 32'd0);

        // 20 items: two bursts, 4 left behind
        push_n(20, 1'b1, 1'b0);
        idle_cycles(15, 1'b1);
        check_eq("two_bursts_left", 32'(fq.size()), 32'd4);

        // Stall pattern 1,0,0,1 then random ready
        push_n(4, 1'b1, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) run_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        idle_cycles(10, 1'b1);
        check_eq("stall_drained", 32'(fq.size()), 32'd0);

        // Reset after beat 3 of a burst
        push_n(8, 1'b0, 1'b0);
        for (int i = 0; i < 30 && !(mdl_busy && mdl_beat == 4); i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("mid_rst_left", 32'(fq.size()), 32'd4);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        push_n(4, 1'b1, 1'b0);
        idle_cycles(15, 1'b1);
        check_eq("after_rst_drained", 32'(fq.size()), 32'd0);

        // Partial data below threshold
        push_n(3, 1'b1, 1'b0);
        idle_cycles(40, 1'b1);
`ifdef FIFO_BURST_RD_TIMEOUT_EN
        check_eq("partial_left", 32'(fq.size()), 32'd0);
`else
        check_eq("partial_left", 32'(fq.size()), 32'd3);
`endif

        // rd_rst_busy holds everything off
        push_n(8, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("rrb_hold", 32'(fq.size() >= BL), 32'd1);
        idle_cycles(20, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            run_cycle((fq.size() < DEPTH - 1) && ($urandom_range(0, 2) != 0),
                      ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 99) != 0));
        end
        idle_cycles(60, 1'b1);
        check_eq("leftover", 32'(fq.size()), 32'(exp_q.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
